// File: rtl/fifo_burst_drain.sv
// Single-clock FIFO with a hysteresis read controller: auto mode drains one word
// per RD_DIV cycles from almost-full down to almost-empty; external mode uses rd_en.
module fifo_burst_drain #(
  parameter int DATA_W    = 31,
  parameter int ADDR_W    = 10,
  parameter int AF_THRESH = 1000,
  parameter int AE_THRESH = 16,
  parameter int RD_DIV    = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              auto_mode,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   level,
  output logic              wr_full,
  output logic              rd_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              drain_active,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PACE_W = (RD_DIV > 1) ? $clog2(RD_DIV) : 1;

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_L      = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0]   AE_L      = (ADDR_W+1)'(AE_THRESH);
  localparam logic [PACE_W-1:0] PACE_LAST = PACE_W'(RD_DIV - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [PACE_W-1:0]   pace, pace_nxt;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                auto_strobe, rreq, rd_acc, wr_acc;

  assign wr_full      = (level == DEPTH_L);
  assign rd_empty     = (level == '0);
  assign almost_full  = (level >= AF_L);
  assign almost_empty = (level <= AE_L);
  assign drain_active = (state == DRAIN);

  always_comb begin
    state_nxt   = state;
    pace_nxt    = pace;
    auto_strobe = 1'b0;
    if (!auto_mode) begin
      state_nxt = IDLE;
      pace_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (almost_full) begin
            state_nxt = DRAIN;
            pace_nxt  = '0;
          end
        end
        DRAIN: begin
          if (almost_empty) begin
            state_nxt = IDLE;
            pace_nxt  = '0;
          end else begin
            auto_strobe = (pace == PACE_LAST);
            pace_nxt    = auto_strobe ? '0 : pace + PACE_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          pace_nxt  = '0;
        end
      endcase
    end
  end

  assign rreq   = auto_mode ? auto_strobe : rd_en;
  assign rd_acc = rreq && !rd_empty;
  assign wr_acc = wr_en && !wr_full;

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge sys_clk) begin
    if (wr_acc && !flush) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      pace      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      pace      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      pace     <= pace_nxt;
      rd_valid <= rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + ADDR_W'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + (ADDR_W+1)'(1);
        2'b01:   level <= level - (ADDR_W+1)'(1);
        default: level <= level;
      endcase
      if (wr_en && wr_full) overflow <= 1'b1;
      if (!auto_mode && rd_en && rd_empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain at DEPTH=16, AF=8, AE=2, RD_DIV=4.
module tb_fifo_burst_drain;

  logic        sys_clk = 1'b0;
  logic        sys_rst, flush, wr_en, auto_mode, rd_en;
  logic [30:0] wr_data;
  logic [30:0] rd_data;
  logic        rd_valid, wr_full, rd_empty, almost_full, almost_empty;
  logic        drain_active, overflow, underflow;
  logic [4:0]  level;

  int checks = 0;
  int errors = 0;

  fifo_burst_drain #(
    .DATA_W   (31),
    .ADDR_W   (4),
    .AF_THRESH(8),
    .AE_THRESH(2),
    .RD_DIV   (4)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .flush       (flush),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .auto_mode   (auto_mode),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .level       (level),
    .wr_full     (wr_full),
    .rd_empty    (rd_empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .drain_active(drain_active),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [30:0] q[$];
  logic [30:0] nxt, exp_d;
  int          exp_lvl;
  logic        v, w, r, wacc, racc;
  int          guard;

  initial begin
    sys_rst = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
    auto_mode = 1'b0; rd_en = 1'b0;
    tick(); tick();
    sys_rst = 1'b0;
    tick();

    // 1: reset asserted mid-traffic
    wr_en = 1'b1; wr_data = 31'hAA; tick();
    wr_data = 31'hBB; tick();
    wr_en = 1'b0; rd_en = 1'b1; tick();
    chk("pre_rst_valid", rd_valid, 1);
    chk("pre_rst_data", rd_data, 31'hAA);
    wr_en = 1'b1; rd_en = 1'b0; wr_data = 31'hCC;
    #1 sys_rst = 1'b1;
    #1;
    chk("rst_data", rd_data, 0);
    chk("rst_level", level, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_drain", drain_active, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_empty", rd_empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    wr_en = 1'b0;
    tick();
    sys_rst = 1'b0;
    tick();

    // 2: external mode ordering
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_data = 31'(i); tick();
    end
    wr_en = 1'b0;
    chk("t2_level3", level, 3);
    rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t2_valid", rd_valid, 1);
      chk("t2_data", rd_data, 32'(i));
    end
    chk("t2_level0", level, 0);
    chk("t2_empty", rd_empty, 1);
    tick();
    chk("t2_udf_valid", rd_valid, 0);
    chk("t2_udf", underflow, 1);
    chk("t2_udf_hold", rd_data, 3);
    rd_en = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    chk("t2_flush_udf", underflow, 0);

    // 3: auto drain with hysteresis
    auto_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 31'h10 + 31'(i); tick();
    end
    wr_en = 1'b0;
    chk("t3_level8", level, 8);
    chk("t3_idle", drain_active, 0);
    tick();
    chk("t3_drain", drain_active, 1);
    exp_lvl = 8; nxt = 31'h10;
    for (int t = 2; t <= 32; t++) begin
      tick();
      v = (t >= 5) && (t <= 25) && (((t - 5) % 4) == 0);
      chk("t3_valid", rd_valid, v);
      if (v) begin
        chk("t3_data", rd_data, nxt);
        nxt++;
        exp_lvl--;
      end
      chk("t3_level", level, exp_lvl);
      chk("t3_drain_flag", drain_active, t <= 25);
    end
    auto_mode = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    chk("t3_flushed", level, 0);

    // 4: overflow at full
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 31'h100 + 31'(i); tick();
      if (i == 15) begin
        chk("t4_full", wr_full, 1);
        chk("t4_level16", level, 16);
        chk("t4_no_ovf", overflow, 0);
      end
    end
    chk("t4_ovf", overflow, 1);
    chk("t4_level_hold", level, 16);
    wr_data = 31'h200; rd_en = 1'b1; tick();
    chk("t4_rw_level", level, 15);
    chk("t4_rw_data", rd_data, 31'h100);
    chk("t4_ovf_sticky", overflow, 1);
    wr_en = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk("t4_drain_data", rd_data, 31'h100 + 31'(k));
    end
    rd_en = 1'b0;
    tick();
    chk("t4_empty", rd_empty, 1);
    chk("t4_valid_end", rd_valid, 0);
    chk("t4_udf", underflow, 0);

    // 5: random simultaneous traffic against a queue model
    for (int c = 0; c < 100; c++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      wr_en = w; rd_en = r;
      wr_data = 31'($urandom);
      wacc = w && (q.size() < 16);
      racc = r && (q.size() > 0);
      tick();
      chk("t5_valid", rd_valid, racc);
      if (racc) begin
        exp_d = q.pop_front();
        chk("t5_data", rd_data, exp_d);
      end
      if (wacc) q.push_back(wr_data);
      chk("t5_level", level, q.size());
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // 6: flush mid-drain
    flush = 1'b1; tick();
    flush = 1'b0;
    rd_en = 1'b1; tick();
    rd_en = 1'b0;
    chk("t6_udf_set", underflow, 1);
    auto_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 31'h30 + 31'(i); tick();
    end
    wr_en = 1'b0;
    guard = 0;
    while (level != 6 && guard < 40) begin
      tick();
      guard++;
    end
    chk("t6_reach6", level, 6);
    chk("t6_in_drain", drain_active, 1);
    flush = 1'b1; tick();
    flush = 1'b0;
    chk("t6_level", level, 0);
    chk("t6_drain", drain_active, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_udf", underflow, 0);
    chk("t6_valid", rd_valid, 0);
    chk("t6_data_kept", rd_data, 31'h31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
